// File: rtl/imem_loader.sv
// imem_loader: streams a program from an 8-bit host byte interface into the
// instruction buffer. It assembles bytes into buffer words, drives the buffer
// write port, and holds the PAT core in reset while a load is in progress.
//
// Host handshake: a byte moves on a rising clk edge where host_valid and
// host_ready are both high. host_ready depends only on the registered state,
// so there is no combinational path from host_valid to host_ready. The host
// may hold host_valid and host_data steady across cycles where host_ready is
// low, and nothing is consumed in those cycles. host_abort in any non-IDLE
// state takes priority over a byte offered in the same cycle; that byte is
// dropped.
module imem_loader #(
  parameter int I_ADR_WIDTH  = 8,
  parameter int I_WORD_WIDTH = 46
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              host_data,
  input  logic                    host_valid,
  output logic                    host_ready,
  input  logic                    host_abort,
  output logic [I_ADR_WIDTH-1:0]  imem_write_adr,
  output logic                    imem_write,
  output logic [I_WORD_WIDTH-1:0] imem_in,
  output logic                    pat_hold,
  output logic                    busy,
  output logic                    done,
  output logic                    load_error,
  output logic [2:0]              state_dbg
);

  localparam int BYTES_PER_WORD = (I_WORD_WIDTH + 7) / 8;
  localparam int ASM_W          = 8 * (BYTES_PER_WORD - 1);
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);
  localparam int CNT_W          = I_ADR_WIDTH + 1;

  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(1) << I_ADR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COUNT   = 3'd1,
    S_DATA    = 3'd2,
    S_WRITE   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        word_cnt;
  logic [BIDX_W-1:0]       byte_idx;
  logic [ASM_W-1:0]        asm_reg;
  logic                    abort_hit;
  logic                    accept;
  logic [I_ADR_WIDTH-1:0]  byte_as_adr;

  assign abort_hit   = host_abort && (state != S_IDLE);
  assign accept      = host_valid && host_ready && !abort_hit;
  assign busy        = (state != S_IDLE);
  assign state_dbg   = state;
  assign byte_as_adr = I_ADR_WIDTH'(host_data);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode plus the state-derived strobes (ready, write, done).
  always_comb begin
    state_next = state;
    host_ready = 1'b0;
    imem_write = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        host_ready = 1'b1;
        if (host_valid) state_next = S_COUNT;
      end
      S_COUNT: begin
        host_ready = 1'b1;
        if (abort_hit)       state_next = S_IDLE;
        else if (host_valid) state_next = S_DATA;
      end
      S_DATA: begin
        host_ready = 1'b1;
        if (abort_hit)                                state_next = S_IDLE;
        else if (host_valid && byte_idx == LAST_BYTE) state_next = S_WRITE;
      end
      S_WRITE: begin
        // The write lands this cycle even if an abort arrives alongside it.
        imem_write = 1'b1;
        if (abort_hit)               state_next = S_IDLE;
        else if (word_cnt == CNT_ONE) state_next = S_RELEASE;
        else                          state_next = S_DATA;
      end
      S_RELEASE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: address, word counter, byte assembly, output word and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_write_adr <= '0;
      imem_in        <= '0;
      word_cnt       <= '0;
      byte_idx       <= '0;
      asm_reg        <= '0;
      pat_hold       <= 1'b0;
      load_error     <= 1'b0;
    end else if (abort_hit) begin
      // Abort leaves the PAT held and the counters untouched.
      load_error <= 1'b1;
      byte_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            imem_write_adr <= byte_as_adr;
            pat_hold       <= 1'b1;
          end
        end
        S_COUNT: begin
          if (accept) begin
            word_cnt <= (byte_as_adr == '0) ? CNT_FULL : CNT_W'(byte_as_adr);
            byte_idx <= '0;
          end
        end
        S_DATA: begin
          if (accept) begin
            if (byte_idx == LAST_BYTE) begin
              // Final byte goes straight into the output word; bits beyond
              // the word width are dropped by the cast.
              imem_in  <= I_WORD_WIDTH'({host_data, asm_reg});
              byte_idx <= '0;
            end else begin
              for (int k = 0; k < BYTES_PER_WORD - 1; k++) begin
                if (byte_idx == BIDX_W'(k)) asm_reg[8*k +: 8] <= host_data;
              end
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        S_WRITE: begin
          imem_write_adr <= imem_write_adr + 1'b1;
          word_cnt       <= word_cnt - CNT_ONE;
        end
        S_RELEASE: begin
          pat_hold   <= 1'b0;
          load_error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: single word, back-to-back words with
// address wrap, 256-word load, gapped stream, aborts and async reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  host_data;
  logic        host_valid;
  logic        host_ready;
  logic        host_abort;
  logic [7:0]  imem_write_adr;
  logic        imem_write;
  logic [45:0] imem_in;
  logic        pat_hold;
  logic        busy;
  logic        done;
  logic        load_error;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int ready_low_cnt = 0;

  logic [7:0]  wr_adr_q[$];
  logic [45:0] wr_dat_q[$];
  int          wr_cyc_q[$];
  logic [45:0] exp_q[$];
  logic [7:0]  exp_adr_q[$];

  imem_loader dut (
    .clk            (clk),
    .reset          (reset),
    .host_data      (host_data),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_abort     (host_abort),
    .imem_write_adr (imem_write_adr),
    .imem_write     (imem_write),
    .imem_in        (imem_in),
    .pat_hold       (pat_hold),
    .busy           (busy),
    .done           (done),
    .load_error     (load_error),
    .state_dbg      (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (imem_write === 1'b1) begin
      wr_adr_q.push_back(imem_write_adr);
      wr_dat_q.push_back(imem_in);
      wr_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (host_ready === 1'b0) ready_low_cnt = ready_low_cnt + 1;
  end

  task automatic clear_obs();
    wr_adr_q.delete();
    wr_dat_q.delete();
    wr_cyc_q.delete();
    exp_q.delete();
    exp_adr_q.delete();
  endtask

  // Offer one byte (after an optional idle gap) and return on the
  // rising edge that accepts it. host_valid stays high afterwards.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    @(negedge clk);
    if (gap > 0) begin
      host_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    host_valid = 1'b1;
    host_data  = b;
    n = 0;
    while (host_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout: host_ready=%b required 1 for byte %h", host_ready, b);
    end
    @(posedge clk);
  endtask

  // Drop valid and wait for done; bounded.
  task automatic wait_done(input string tag, input int budget);
    int n;
    @(negedge clk);
    host_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b required 1", tag, done);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; host_valid = 1'b0; host_abort = 1'b0; host_data = 8'h00;
    repeat (3) @(negedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    checks++; if (host_ready !== 1'b1)     begin errors++; $display("FAIL rst_ready: got %b required 1", host_ready); end
    checks++; if (imem_write !== 1'b0)     begin errors++; $display("FAIL rst_write: got %b required 0", imem_write); end
    checks++; if (imem_write_adr !== 8'h0) begin errors++; $display("FAIL rst_adr: got %h required 00", imem_write_adr); end
    checks++; if (imem_in !== 46'h0)       begin errors++; $display("FAIL rst_data: got %h required 0", imem_in); end
    checks++; if (pat_hold !== 1'b0)       begin errors++; $display("FAIL rst_hold: got %b required 0", pat_hold); end
    checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0)           begin errors++; $display("FAIL rst_done: got %b required 0", done); end
    checks++; if (load_error !== 1'b0)     begin errors++; $display("FAIL rst_err: got %b required 0", load_error); end
  endtask

  // Single-word load at 0x10; exp_err is the load_error level expected
  // while the load runs.
  task automatic run_basic(input string tag, input logic exp_err);
    logic [7:0] d [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF};
    clear_obs();
    send_byte(8'h10, 0);
    #1;
    checks++; if (pat_hold !== 1'b1)        begin errors++; $display("FAIL %s_hold_after_adr: got %b required 1", tag, pat_hold); end
    checks++; if (imem_write_adr !== 8'h10) begin errors++; $display("FAIL %s_adr_load: got %h required 10", tag, imem_write_adr); end
    send_byte(8'h01, 0);
    for (int i = 0; i < 6; i++) send_byte(d[i], 0);
    @(negedge clk);
    host_valid = 1'b0;
    checks++; if (imem_write !== 1'b1)               begin errors++; $display("FAIL %s_write: got %b required 1", tag, imem_write); end
    checks++; if (imem_write_adr !== 8'h10)          begin errors++; $display("FAIL %s_wadr: got %h required 10", tag, imem_write_adr); end
    checks++; if (imem_in !== 46'h3F_0504_0302_01)   begin errors++; $display("FAIL %s_wdata: got %h required 3f0504030201", tag, imem_in); end
    checks++; if (host_ready !== 1'b0)               begin errors++; $display("FAIL %s_ready_in_write: got %b required 0", tag, host_ready); end
    checks++; if (load_error !== exp_err)            begin errors++; $display("FAIL %s_err_during: got %b required %b", tag, load_error, exp_err); end
    @(negedge clk);
    checks++; if (done !== 1'b1)       begin errors++; $display("FAIL %s_done_pulse: got %b required 1", tag, done); end
    checks++; if (imem_write !== 1'b0) begin errors++; $display("FAIL %s_write_one_cycle: got %b required 0", tag, imem_write); end
    checks++; if (pat_hold !== 1'b1)   begin errors++; $display("FAIL %s_hold_in_release: got %b required 1", tag, pat_hold); end
    @(negedge clk);
    checks++; if (done !== 1'b0)                   begin errors++; $display("FAIL %s_done_after: got %b required 0", tag, done); end
    checks++; if (pat_hold !== 1'b0)               begin errors++; $display("FAIL %s_hold_released: got %b required 0", tag, pat_hold); end
    checks++; if (busy !== 1'b0)                   begin errors++; $display("FAIL %s_busy_idle: got %b required 0", tag, busy); end
    checks++; if (load_error !== 1'b0)             begin errors++; $display("FAIL %s_err_cleared: got %b required 0", tag, load_error); end
    checks++; if (host_ready !== 1'b1)             begin errors++; $display("FAIL %s_ready_idle: got %b required 1", tag, host_ready); end
    checks++; if (imem_write_adr !== 8'h11)        begin errors++; $display("FAIL %s_adr_incr: got %h required 11", tag, imem_write_adr); end
    checks++; if (imem_in !== 46'h3F_0504_0302_01) begin errors++; $display("FAIL %s_data_stable: got %h required 3f0504030201", tag, imem_in); end
    checks++; if (wr_adr_q.size() != 1)            begin errors++; $display("FAIL %s_write_count: got %0d required 1", tag, wr_adr_q.size()); end
  endtask

  task automatic test_basic();
    run_basic("basic", 1'b0);
  endtask

  // Three words from 0xFE; used both gap-free and with gaps.
  task automatic run_three(input string tag, input logic gaps);
    logic [7:0] d [18] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hC5,
                           8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h7F,
                           8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40};
    clear_obs();
    exp_adr_q = '{8'hFE, 8'hFF, 8'h00};
    exp_q     = '{46'h05_A4A3_A2A1_A0, 46'h3F_B4B3_B2B1_B0, 46'h00_4433_2211_00};
    ready_low_cnt = 0;
    send_byte(8'hFE, 0);
    send_byte(8'h03, 0);
    for (int i = 0; i < 18; i++) begin
      send_byte(d[i], gaps ? int'($urandom_range(0, 3)) : 0);
      if (gaps && i == 4) begin
        @(negedge clk);
        host_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (wr_adr_q.size() != 0) begin errors++; $display("FAIL %s_early_write: got %0d writes required 0", tag, wr_adr_q.size()); end
      end
    end
    wait_done(tag, 20);
    checks++;
    if (wr_adr_q.size() != 3) begin
      errors++; $display("FAIL %s_write_count: got %0d required 3", tag, wr_adr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (wr_adr_q[i] !== exp_adr_q[i]) begin errors++; $display("FAIL %s_adr%0d: got %h required %h", tag, i, wr_adr_q[i], exp_adr_q[i]); end
        checks++; if (wr_dat_q[i] !== exp_q[i])     begin errors++; $display("FAIL %s_dat%0d: got %h required %h", tag, i, wr_dat_q[i], exp_q[i]); end
      end
      if (!gaps) begin
        checks++; if (wr_cyc_q[1] - wr_cyc_q[0] != 7) begin errors++; $display("FAIL %s_rate01: got %0d required 7", tag, wr_cyc_q[1] - wr_cyc_q[0]); end
        checks++; if (wr_cyc_q[2] - wr_cyc_q[1] != 7) begin errors++; $display("FAIL %s_rate12: got %0d required 7", tag, wr_cyc_q[2] - wr_cyc_q[1]); end
        checks++; if (done_cyc - wr_cyc_q[2] != 1)    begin errors++; $display("FAIL %s_done_lat: got %0d required 1", tag, done_cyc - wr_cyc_q[2]); end
        checks++; if (ready_low_cnt != 4)             begin errors++; $display("FAIL %s_ready_low: got %0d required 4", tag, ready_low_cnt); end
      end
    end
    checks++; if (imem_write_adr !== 8'h01) begin errors++; $display("FAIL %s_final_adr: got %h required 01", tag, imem_write_adr); end
  endtask

  task automatic test_back_to_back();
    run_three("b2b", 1'b0);
  endtask

  task automatic test_gaps();
    run_three("gaps", 1'b1);
  endtask

  task automatic test_count_256();
    int d0;
    clear_obs();
    d0 = done_cnt;
    send_byte(8'h80, 0);
    send_byte(8'h00, 0);
    for (int w = 0; w < 256; w++) begin
      logic [7:0] lo;
      lo = w[7:0];
      exp_adr_q.push_back(8'h80 + lo);
      exp_q.push_back({6'h00, 8'h5A, 8'h5A, 8'h5A, 8'h5A, lo});
      send_byte(lo, 0);
      for (int k = 0; k < 4; k++) send_byte(8'h5A, 0);
      send_byte(8'hC0, 0);
    end
    wait_done("c256", 20);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL c256_done_count: got %0d required 1", done_cnt - d0); end
    checks++;
    if (wr_adr_q.size() != 256) begin
      errors++; $display("FAIL c256_write_count: got %0d required 256", wr_adr_q.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        checks++; if (wr_adr_q[i] !== exp_adr_q[i]) begin errors++; $display("FAIL c256_adr%0d: got %h required %h", i, wr_adr_q[i], exp_adr_q[i]); end
        checks++; if (wr_dat_q[i] !== exp_q[i])     begin errors++; $display("FAIL c256_dat%0d: got %h required %h", i, wr_dat_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_abort_data();
    clear_obs();
    send_byte(8'h20, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    @(negedge clk);
    host_valid = 1'b0;
    host_abort = 1'b1;
    @(negedge clk);
    host_abort = 1'b0;
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL abort_err: got %b required 1", load_error); end
    checks++; if (pat_hold !== 1'b1)   begin errors++; $display("FAIL abort_hold: got %b required 1", pat_hold); end
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b required 1", host_ready); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (wr_adr_q.size() != 0) begin errors++; $display("FAIL abort_no_write: got %0d required 0", wr_adr_q.size()); end
    run_basic("after_abort", 1'b1);
  endtask

  task automatic test_abort_write();
    logic [7:0] d [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h11};
    clear_obs();
    send_byte(8'h40, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 6; i++) send_byte(d[i], 0);
    @(negedge clk);
    host_valid = 1'b0;
    host_abort = 1'b1;
    checks++; if (imem_write !== 1'b1)           begin errors++; $display("FAIL abw_write: got %b required 1", imem_write); end
    checks++; if (imem_in !== 46'h11_EEDD_CCBB_AA) begin errors++; $display("FAIL abw_data: got %h required 11eeddccbbaa", imem_in); end
    @(negedge clk);
    host_abort = 1'b0;
    checks++; if (busy !== 1'b0)            begin errors++; $display("FAIL abw_busy: got %b required 0", busy); end
    checks++; if (imem_write !== 1'b0)      begin errors++; $display("FAIL abw_write_off: got %b required 0", imem_write); end
    checks++; if (imem_write_adr !== 8'h40) begin errors++; $display("FAIL abw_adr_held: got %h required 40", imem_write_adr); end
    checks++; if (load_error !== 1'b1)      begin errors++; $display("FAIL abw_err: got %b required 1", load_error); end
    checks++; if (pat_hold !== 1'b1)        begin errors++; $display("FAIL abw_hold: got %b required 1", pat_hold); end
    checks++; if (done !== 1'b0)            begin errors++; $display("FAIL abw_done: got %b required 0", done); end
  endtask

  task automatic test_async_reset();
    send_byte(8'h55, 0);
    send_byte(8'h01, 0);
    send_byte(8'h9A, 0);
    send_byte(8'h9B, 0);
    send_byte(8'h9C, 0);
    @(negedge clk);
    host_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (pat_hold !== 1'b0)       begin errors++; $display("FAIL arst_hold: got %b required 0", pat_hold); end
    checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL arst_busy: got %b required 0", busy); end
    checks++; if (load_error !== 1'b0)     begin errors++; $display("FAIL arst_err: got %b required 0", load_error); end
    checks++; if (imem_in !== 46'h0)       begin errors++; $display("FAIL arst_data: got %h required 0", imem_in); end
    checks++; if (imem_write_adr !== 8'h0) begin errors++; $display("FAIL arst_adr: got %h required 00", imem_write_adr); end
    checks++; if (imem_write !== 1'b0)     begin errors++; $display("FAIL arst_write: got %b required 0", imem_write); end
    checks++; if (host_ready !== 1'b1)     begin errors++; $display("FAIL arst_ready: got %b required 1", host_ready); end
    #4 reset = 1'b1;
    run_basic("after_arst", 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_gaps();
    test_count_256();
    test_abort_data();
    test_abort_write();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Host-side sequencer that streams a program into the instruction buffer over an 8-bit valid/ready byte interface.
- Assembles bytes into full instruction-buffer words and drives the buffer write port: address, write strobe and data.
- Holds the PAT core in reset for the whole load and releases it only after the last word is written.
- Sits beside the instruction buffer in the digital top. Its pat_hold output is ORed into the PAT reset.

Parameters:
- I_ADR_WIDTH, 8, instruction address width; also sets the word-count range.
- I_WORD_WIDTH, 46, write-port data width (i_buffer_size*i_width).
- BYTES_PER_WORD, derived localparam = ceil(I_WORD_WIDTH/8) = 6; not overridable.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- host_data  in  8  byte from host.
- host_valid  in  1  host_data is valid.
- host_ready  out  1  loader accepts a byte this cycle.
- host_abort  in  1  abort the current load; ignored in IDLE.
- imem_write_adr  out  I_ADR_WIDTH  instruction-buffer write address.
- imem_write  out  1  one-cycle write strobe.
- imem_in  out  I_WORD_WIDTH  write data.
- pat_hold  out  1  hold the PAT in reset.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a load completes.
- load_error  out  1  sticky; a load was aborted.

Behaviour:
- A byte is accepted on a clock edge where host_valid && host_ready. There is no combinational path from host_valid to host_ready.
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - host_ready=1, imem_write=0, imem_write_adr=0, imem_in=0.
  - pat_hold=0, busy=0, done=0, load_error=0.
  - Byte counter, word counter and assembly register are cleared.
  - Asserting reset mid-load discards the partial word and leaves pat_hold=0.
- Stream format: [start address byte][count byte][count words, each BYTES_PER_WORD bytes, least-significant byte first].
  - Byte k of a word maps to bits [8k+7:8k] of the word.
  - Bits at or above I_WORD_WIDTH are discarded: the top 2 bits of byte 5 at the defaults.
  - count=0 means 2^I_ADR_WIDTH words (256).
- States:
  - IDLE: host_ready=1. An accepted byte loads the address register, sets pat_hold=1 and moves to COUNT.
  - COUNT: host_ready=1. An accepted byte loads the word counter (I_ADR_WIDTH+1 bits, 0 mapped to 256) and moves to DATA.
  - DATA: host_ready=1. Each accepted byte goes to the assembly register at the current byte index. On acceptance of byte BYTES_PER_WORD-1, move to WRITE.
  - WRITE: exactly one cycle, host_ready=0.
    - imem_write=1, imem_in = assembled word, imem_write_adr = current address.
    - Next cycle: address increments mod 2^I_ADR_WIDTH (255 wraps to 0) and the word counter decrements.
    - If the remaining count was 1, move to RELEASE; otherwise return to DATA with the byte index at 0.
  - RELEASE: one cycle, host_ready=0, done=1, pat_hold drops to 0 on the edge leaving RELEASE. Clears load_error. Then IDLE.
- Latency: last byte accepted at edge t → imem_write high in cycle t+1 → host_ready high again in cycle t+2.
  - Sustained rate: 1 word per BYTES_PER_WORD+1 cycles.
- imem_in and imem_write_adr are registered and stay stable between strobes. imem_in changes only when entering WRITE; imem_write_adr changes only after WRITE or on the address byte.
- host_abort in any non-IDLE state (highest priority over byte acceptance):
  - Next state is IDLE, load_error=1, pat_hold stays 1, no further write.
  - If the abort coincides with a WRITE cycle, that write still completes this cycle. The counter is not updated.
- pat_hold and load_error stay asserted until a later load reaches RELEASE or until reset.
- busy = (state != IDLE).

Test Plan:
- Reset, then stream 0x10, 0x01, 01 02 03 04 05 FF → one imem_write with imem_write_adr=0x10, imem_in=46'h3F_0504_0302_01. done pulses 1 cycle after the write; pat_hold is high from the cycle after byte 0 until after RELEASE.
- Start 0xFE, count 3, valid held high → writes at 0xFE, 0xFF, 0x00. host_ready is low only in WRITE/RELEASE cycles. 3×7 data+write cycles total.
- Count byte 0x00 → exactly 256 writes at addresses start..start-1 (wrapping), then done.
- Random host_valid gaps during DATA → identical write contents and addresses to the gap-free run. No write before the 6th byte.
- host_abort after 3 data bytes → no write, busy=0 next cycle, load_error=1, pat_hold=1. A following complete load clears both flags at done.
- Async reset pulse mid-word (not aligned to clk) → all outputs are 0 immediately. A subsequent fresh load behaves exactly as the first scenario.
